// File: rtl/abs_diff_pkg.sv
// Shared constants, FSM state type and width helpers for the abs-diff accumulator.
package abs_diff_pkg;

  localparam int unsigned ABS_MODE_TRUE   = 0;
  localparam int unsigned ABS_MODE_LEGACY = 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int unsigned lane_sum_w(input int unsigned w, input int unsigned lanes);
    return w + $clog2(lanes);
  endfunction

  function automatic int unsigned skip_cnt_w(input int unsigned lanes, input int unsigned max_beats);
    return $clog2(lanes * max_beats) + 1;
  endfunction

  function automatic int unsigned beats_cnt_w(input int unsigned max_beats);
    return $clog2(max_beats) + 1;
  endfunction

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/abs_diff_lane.sv
// Combinational single-lane magnitude with sentinel skip detection.
module abs_diff_lane
  import abs_diff_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned ABS_MODE = ABS_MODE_TRUE,
  parameter int unsigned SKIP_EN  = 1,
  parameter int unsigned SKIP_VAL = 1
) (
  input  logic [W-1:0] moto_i,
  input  logic [W-1:0] hik_i,
  output logic [W-1:0] mag_o,
  output logic         skip_o
);

  logic [W-1:0] raw;

  generate
    if (ABS_MODE == ABS_MODE_LEGACY) begin : g_legacy
      // Wrapped W-bit difference, negated when its MSB reads as negative.
      logic [W-1:0] d;
      assign d   = moto_i - hik_i;
      assign raw = d[W-1] ? (~d + W'(1)) : d;
    end else begin : g_true
      logic [W:0] d;
      assign d   = {1'b0, moto_i} - {1'b0, hik_i};
      assign raw = d[W] ? (hik_i - moto_i) : W'(d);
    end
  endgenerate

  assign skip_o = (SKIP_EN != 0) && (moto_i == W'(SKIP_VAL));
  assign mag_o  = skip_o ? '0 : raw;

endmodule

// File: rtl/abs_diff_accum.sv
// Multi-lane |moto - hikareru| pipeline accumulating sum/max/skip per frame.
module abs_diff_accum
  import abs_diff_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned SUM_W     = W + $clog2(LANES) + $clog2(MAX_BEATS),
  parameter int unsigned ABS_MODE  = ABS_MODE_TRUE,
  parameter int unsigned SKIP_EN   = 1,
  parameter int unsigned SKIP_VAL  = 1,
  localparam int unsigned SKIP_W   = skip_cnt_w(LANES, MAX_BEATS),
  localparam int unsigned BEATS_W  = beats_cnt_w(MAX_BEATS)
) (
  input  logic                 m_clock,
  input  logic                 p_reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_moto,
  input  logic [LANES*W-1:0]   in_hikareru,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_W-1:0]     out_sum,
  output logic [W-1:0]         out_max,
  output logic [SKIP_W-1:0]    out_skip,
  output logic [BEATS_W-1:0]   out_beats,
  output logic                 out_sat
);

  localparam int unsigned LSUM_W = lane_sum_w(W, LANES);
  localparam int unsigned LSK_W  = $clog2(LANES) + 1;
  localparam int unsigned ADD_W  = max_w(SUM_W, LSUM_W) + 1;
  localparam int unsigned SKW1   = SKIP_W + 1;

  state_e state_q;
  logic   in_ready_q, out_valid_q, done_q;
  logic   accept;

  logic [LANES-1:0][W-1:0] lane_mag;
  logic [LANES-1:0]        lane_skip;

  logic                    s1_vld_q, s1_last_q;
  logic [LANES-1:0][W-1:0] s1_mag_q;
  logic [LANES-1:0]        s1_skip_q;

  logic [LSUM_W-1:0] bsum_d, s2_sum_q;
  logic [W-1:0]      bmax_d, s2_max_q;
  logic [LSK_W-1:0]  bskip_d, s2_skip_q;
  logic              s2_vld_q, s2_last_q;

  logic [SUM_W-1:0]   acc_sum_q, acc_sum_d;
  logic [W-1:0]       acc_max_q, acc_max_d;
  logic [SKIP_W-1:0]  acc_skip_q, acc_skip_d;
  logic [BEATS_W-1:0] acc_beats_q, acc_beats_d;
  logic               acc_sat_q, acc_sat_d;

  logic [ADD_W-1:0] sum_wide;
  logic [SKW1-1:0]  skip_wide;

  assign accept = in_valid & in_ready_q;

  generate
    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
      abs_diff_lane #(
        .W        (W),
        .ABS_MODE (ABS_MODE),
        .SKIP_EN  (SKIP_EN),
        .SKIP_VAL (SKIP_VAL)
      ) u_lane (
        .moto_i (in_moto[g*W +: W]),
        .hik_i  (in_hikareru[g*W +: W]),
        .mag_o  (lane_mag[g]),
        .skip_o (lane_skip[g])
      );
    end
  endgenerate

  // Per-beat reduction of the S1 lane results; skipped lanes carry magnitude 0.
  always_comb begin
    bsum_d  = '0;
    bmax_d  = '0;
    bskip_d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      bsum_d  = bsum_d + LSUM_W'(s1_mag_q[i]);
      bskip_d = bskip_d + LSK_W'(s1_skip_q[i]);
      if (s1_mag_q[i] > bmax_d) bmax_d = s1_mag_q[i];
    end
  end

  // Saturating accumulator update from S2.
  always_comb begin
    sum_wide    = ADD_W'(acc_sum_q) + ADD_W'(s2_sum_q);
    skip_wide   = SKW1'(acc_skip_q) + SKW1'(s2_skip_q);
    acc_sum_d   = (|sum_wide[ADD_W-1:SUM_W]) ? '1 : sum_wide[SUM_W-1:0];
    acc_sat_d   = acc_sat_q | (|sum_wide[ADD_W-1:SUM_W]);
    acc_skip_d  = skip_wide[SKIP_W] ? '1 : skip_wide[SKIP_W-1:0];
    acc_max_d   = (s2_max_q > acc_max_q) ? s2_max_q : acc_max_q;
    acc_beats_d = (acc_beats_q == BEATS_W'(MAX_BEATS)) ? acc_beats_q : acc_beats_q + BEATS_W'(1);
  end

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_skip_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_max_q    <= '0;
      s2_skip_q   <= '0;
      acc_sum_q   <= '0;
      acc_max_q   <= '0;
      acc_skip_q  <= '0;
      acc_beats_q <= '0;
      acc_sat_q   <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_mag_q  <= lane_mag;
        s1_skip_q <= lane_skip;
        s1_last_q <= in_last;
      end

      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_vld_q & s1_last_q;
      s2_sum_q  <= bsum_d;
      s2_max_q  <= bmax_d;
      s2_skip_q <= bskip_d;

      done_q <= s2_vld_q & s2_last_q;
      if (s2_vld_q) begin
        acc_sum_q   <= acc_sum_d;
        acc_sat_q   <= acc_sat_d;
        acc_skip_q  <= acc_skip_d;
        acc_max_q   <= acc_max_d;
        acc_beats_q <= acc_beats_d;
      end

      case (state_q)
        ACCUM: begin
          if (accept && in_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        DRAIN: begin
          // The final beat has landed in the accumulators one edge earlier.
          if (done_q) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            acc_sum_q   <= '0;
            acc_max_q   <= '0;
            acc_skip_q  <= '0;
            acc_beats_q <= '0;
            acc_sat_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_sum_q;
  assign out_max   = acc_max_q;
  assign out_skip  = acc_skip_q;
  assign out_beats = acc_beats_q;
  assign out_sat   = acc_sat_q;

endmodule
